// File: rtl/cgra_tcdm_responder.sv
// TCDM slave: word-interleaved multi-bank scratchpad with per-bank round-robin
// arbitration, combinational grant and a fixed one-cycle response.
module cgra_tcdm_responder #(
  parameter int unsigned N_PORTS        = 4,
  parameter int unsigned N_BANKS        = 4,
  parameter int unsigned WORDS_PER_BANK = 256,
  parameter int unsigned DATA_W         = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_PORTS-1:0]              tcdm_req_i,
  input  logic [N_PORTS-1:0][31:0]        tcdm_add_i,
  input  logic [N_PORTS-1:0]              tcdm_wen_i,
  input  logic [N_PORTS-1:0][DATA_W/8-1:0] tcdm_be_i,
  input  logic [N_PORTS-1:0][DATA_W-1:0]  tcdm_wdata_i,
  output logic [N_PORTS-1:0]              tcdm_gnt_o,
  output logic [N_PORTS-1:0][DATA_W-1:0]  tcdm_rdata_o,
  output logic [N_PORTS-1:0]              tcdm_r_valid_o,
  input  logic [N_PORTS-1:0]              gnt_mask_i,
  output logic [31:0]                     conflicts_o
);

  localparam int unsigned BANK_W  = $clog2(N_BANKS);
  localparam int unsigned ROW_W   = $clog2(WORDS_PER_BANK);
  localparam int unsigned PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned ADDR_HI = 2 + BANK_W + ROW_W;

  logic [DATA_W-1:0]                 r_mem [N_BANKS][WORDS_PER_BANK];
  logic [N_BANKS-1:0][PTR_W-1:0]     r_ptr;
  logic [N_PORTS-1:0]                r_rvalid;
  logic [N_PORTS-1:0][DATA_W-1:0]    r_rdata;
  logic [31:0]                       r_conf;

  logic [N_PORTS-1:0][BANK_W-1:0]    w_bank;
  logic [N_PORTS-1:0][ROW_W-1:0]     w_row;
  logic [N_PORTS-1:0]                w_elig;
  logic [N_PORTS-1:0]                w_gnt;
  logic [N_BANKS-1:0]                w_bank_gnt;
  logic [N_BANKS-1:0][PTR_W-1:0]     w_win;
  logic                              w_conflict;
  logic                              w_unused;

  // Address decode; nothing is eligible while reset is held
  always_comb begin
    w_unused = 1'b0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      w_bank[p] = tcdm_add_i[p][2 +: BANK_W];
      w_row[p]  = tcdm_add_i[p][2+BANK_W +: ROW_W];
      w_unused  = w_unused ^ (^tcdm_add_i[p][1:0]) ^ (^tcdm_add_i[p][31:ADDR_HI]);
    end
    w_elig = tcdm_req_i & ~gnt_mask_i & {N_PORTS{~rst_i}};
  end

  // Per-bank round-robin: first eligible port at or after the bank pointer
  always_comb begin : arb
    logic [PTR_W-1:0] v_idx;
    int               v_sum;
    int               v_cnt;
    logic             v_found;
    w_gnt      = '0;
    w_bank_gnt = '0;
    w_win      = '0;
    w_conflict = 1'b0;
    v_idx      = '0;
    v_sum      = 0;
    v_cnt      = 0;
    v_found    = 1'b0;
    for (int b = 0; b < int'(N_BANKS); b++) begin
      v_cnt   = 0;
      v_found = 1'b0;
      for (int k = 0; k < int'(N_PORTS); k++) begin
        v_sum = int'(r_ptr[b]) + k;
        if (v_sum >= int'(N_PORTS)) v_sum = v_sum - int'(N_PORTS);
        v_idx = PTR_W'(v_sum);
        if (w_elig[v_idx] && (w_bank[v_idx] == BANK_W'(b))) begin
          if (!v_found) begin
            v_found      = 1'b1;
            w_gnt[v_idx] = 1'b1;
            w_win[b]     = v_idx;
          end
          v_cnt = v_cnt + 1;
        end
      end
      w_bank_gnt[b] = v_found;
      if (v_cnt >= 2) w_conflict = 1'b1;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (w_gnt[p] && !tcdm_wen_i[p]) begin
        for (int i = 0; i < int'(BE_W); i++) begin
          if (tcdm_be_i[p][i]) r_mem[w_bank[p]][w_row[p]][i*8 +: 8] <= tcdm_wdata_i[p][i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_conf   <= '0;
    end else begin
      for (int b = 0; b < int'(N_BANKS); b++) begin
        if (w_bank_gnt[b]) begin
          r_ptr[b] <= (w_win[b] == PTR_W'(N_PORTS - 1)) ? '0 : w_win[b] + PTR_W'(1);
        end
      end
      r_rvalid <= w_gnt;
      for (int p = 0; p < int'(N_PORTS); p++) begin
        if (w_gnt[p]) r_rdata[p] <= tcdm_wen_i[p] ? r_mem[w_bank[p]][w_row[p]] : '0;
      end
      if (w_conflict && (r_conf != '1)) r_conf <= r_conf + 32'd1;
    end
  end

  assign tcdm_gnt_o     = w_gnt;
  assign tcdm_rdata_o   = r_rdata;
  assign tcdm_r_valid_o = r_rvalid;
  assign conflicts_o    = r_conf;

endmodule

// File: tb/tb_cgra_tcdm_responder.sv
// Randomized bench for cgra_tcdm_responder against a word-level memory and
// arbitration model, plus directed scenarios with literal expectations.
module tb_cgra_tcdm_responder;

  localparam int NP  = 4;
  localparam int NB  = 4;
  localparam int WPB = 256;
  localparam int NW  = NB * WPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]       req, wen, mask;
  logic [NP-1:0][31:0] add, wdata;
  logic [NP-1:0][3:0]  be;
  logic [NP-1:0]       gnt, rv;
  logic [NP-1:0][31:0] rdata;
  logic [31:0]         conf;

  cgra_tcdm_responder #(.N_PORTS(NP), .N_BANKS(NB), .WORDS_PER_BANK(WPB), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .tcdm_req_i(req), .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be),
    .tcdm_wdata_i(wdata), .tcdm_gnt_o(gnt), .tcdm_rdata_o(rdata),
    .tcdm_r_valid_o(rv), .gnt_mask_i(mask), .conflicts_o(conf)
  );

  logic [31:0]   m_mem [NW];
  int            m_ptr [NB];
  logic [NP-1:0] e_rv;
  logic [31:0]   e_rdata [NP];
  logic [31:0]   e_conf;
  logic [NP-1:0] last_g;
  int            n_chk, n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Winner of a bank = eligible candidate with the smallest cyclic distance from the pointer
  function automatic logic [NP-1:0] model_gnt();
    logic [NP-1:0] g;
    int best, bestd, d;
    g = '0;
    for (int b = 0; b < NB; b++) begin
      best = -1; bestd = NP;
      for (int p = 0; p < NP; p++) begin
        if (req[p] && !mask[p] && !rst && (widx(add[p]) % NB == b)) begin
          d = (p - m_ptr[b] + NP) % NP;
          if (d < bestd) begin bestd = d; best = p; end
        end
      end
      if (best >= 0) g[best] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic model_conflict();
    int cnt [NB];
    logic c;
    c = 1'b0;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    for (int p = 0; p < NP; p++)
      if (req[p] && !mask[p]) cnt[widx(add[p]) % NB]++;
    for (int b = 0; b < NB; b++) if (cnt[b] >= 2) c = 1'b1;
    return c;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    for (int p = 0; p < NP; p++) e_rdata[p] = 32'h0;
    e_rv = '0; e_conf = 32'h0; last_g = '0;
  endtask

  // One clock: check grant, advance model, check registered outputs after the edge
  task automatic step();
    logic [NP-1:0] g;
    logic c;
    int idx;
    #1;
    g = model_gnt();
    c = model_conflict();
    chk("gnt", 32'(gnt), 32'(g));
    for (int p = 0; p < NP; p++) begin
      if (g[p]) begin
        idx = widx(add[p]);
        if (wen[p]) e_rdata[p] = m_mem[idx];
        else begin
          e_rdata[p] = 32'h0;
          for (int i = 0; i < 4; i++) if (be[p][i]) m_mem[idx][i*8 +: 8] = wdata[p][i*8 +: 8];
        end
        m_ptr[idx % NB] = (p + 1) % NP;
      end
    end
    e_rv = g;
    last_g = g;
    if (c && e_conf != 32'hFFFF_FFFF) e_conf = e_conf + 32'd1;
    @(posedge clk); #1;
    chk("r_valid", 32'(rv), 32'(e_rv));
    for (int p = 0; p < NP; p++) chk($sformatf("rdata%0d", p), rdata[p], e_rdata[p]);
    chk("conflicts", conf, e_conf);
  endtask

  task automatic idle();
    req = '0; mask = '0;
  endtask

  task automatic drive(input int p, input logic rd, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; wen[p] = rd; add[p] = a; be[p] = b; wdata[p] = d;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; req = '0; wen = '0; mask = '0; add = '0; wdata = '0; be = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(rv), 32'h0);
    for (int p = 0; p < NP; p++) chk("rst_rdata", rdata[p], 32'h0);
    chk("rst_conf", conf, 32'h0);
    rst = 1'b0;

    // Preload every word: port p fills bank p, one row per cycle
    for (int r = 0; r < WPB; r++) begin
      for (int p = 0; p < NP; p++) drive(p, 1'b0, 32'((r * NB + p) * 4), 4'hF, $urandom);
      step();
    end
    idle();

    // Reset again so directed tests start from zeroed pointers
    rst = 1'b1; model_reset();
    @(posedge clk); #1;
    chk("rst2_rvalid", 32'(rv), 32'h0);
    rst = 1'b0;

    // Single write/read
    drive(0, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF);
    #1 chk("t1_wr_gnt", 32'(gnt), 32'h1);
    step();
    chk("t1_wr_rv", 32'(rv), 32'h1);
    chk("t1_wr_rdata", rdata[0], 32'h0);
    drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
    step();
    chk("t1_rd_rv", 32'(rv), 32'h1);
    chk("t1_rd_rdata", rdata[0], 32'hDEAD_BEEF);
    idle(); step();
    chk("t1_idle_rv", 32'(rv), 32'h0);
    chk("t1_hold_rdata", rdata[0], 32'hDEAD_BEEF);

    // Byte enables
    drive(0, 1'b0, 32'h20, 4'hF, 32'hFFFF_FFFF); step();
    drive(0, 1'b0, 32'h20, 4'b0101, 32'h0); step();
    drive(0, 1'b1, 32'h20, 4'h0, 32'h0); step();
    chk("t2_be_rdata", rdata[0], 32'hFF00_FF00);

    // Parallel banks
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 32'(p * 4), 4'h0, 32'h0);
    #1 chk("t3_gnt", 32'(gnt), 32'hF);
    step();
    chk("t3_rv", 32'(rv), 32'hF);
    chk("t3_conf", conf, 32'h0);

    // Conflict on bank 3 (pointer is 0 after port 3 used it above)
    for (int k = 0; k < NP; k++) begin
      idle();
      for (int p = k; p < NP; p++) drive(p, 1'b1, 32'h4C, 4'h0, 32'h0);
      #1 chk("t4_gnt", 32'(gnt), 32'(1 << k));
      step();
      chk("t4_rv", 32'(rv), 32'(1 << k));
      chk("t4_conf", conf, 32'((k + 1 < 3) ? k + 1 : 3));
    end

    // Stall injection
    idle(); mask = 4'b0001;
    drive(0, 1'b1, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("t5_mask_gnt", 32'(gnt), 32'h0);
      step();
      chk("t5_mask_rv", 32'(rv), 32'h0);
    end
    mask = '0;
    #1 chk("t5_unmask_gnt", 32'(gnt), 32'h1);
    step();
    chk("t5_unmask_rv", 32'(rv), 32'h1);

    // Reset on the grant cycle of a read
    idle(); drive(0, 1'b0, 32'h80, 4'hF, 32'h1234_5678); step();
    idle(); drive(0, 1'b1, 32'h80, 4'h0, 32'h0);
    #1 chk("t6_gnt", 32'(gnt), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_rv", 32'(rv), 32'h0);
    idle(); rst = 1'b0; model_reset();
    @(posedge clk); #1;
    chk("t6_post_rv", 32'(rv), 32'h0);
    chk("t6_post_conf", conf, 32'h0);
    drive(0, 1'b1, 32'h80, 4'h0, 32'h0); step();
    chk("t6_old_data", rdata[0], 32'h1234_5678);

    // Random traffic; ungranted requests hold their payload
    idle();
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req[p] && !last_g[p])) begin
          req[p]   = ($urandom_range(0, 3) != 0);
          wen[p]   = 1'($urandom_range(0, 1));
          be[p]    = 4'($urandom);
          wdata[p] = $urandom;
          add[p]   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) * 4)
                     | 32'($urandom_range(0, 3));
        end
      end
      mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      step();
    end
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
